// File: rtl/bitreverse_var_if.sv
// Sample-stream bundle between the last FFT stage and the bit-reversal buffer.
// Carries the i_ce-qualified input sample with its framing/config, and the
// reordered output sample with its frame marker.
//   i_ce      sample strobe
//   i_sync    i_in is sample 0 of a frame (with i_ce)
//   i_lgsize  requested log2 frame size, sampled at frame start
//   i_bypass  pass-through request, sampled at frame start
//   i_in      input sample {real, imag}
//   o_out     reordered sample {real, imag}
//   o_sync    o_out carries natural-order sample 0
interface bitreverse_var_if #(
  parameter int WIDTH = 16,
  parameter int LGW   = 4
);
  logic               i_ce;
  logic               i_sync;
  logic [LGW-1:0]     i_lgsize;
  logic               i_bypass;
  logic [2*WIDTH-1:0] i_in;
  logic [2*WIDTH-1:0] o_out;
  logic               o_sync;

  // Producer side (upstream FFT stage / testbench)
  modport master (
    output i_ce, i_sync, i_lgsize, i_bypass, i_in,
    input  o_out, o_sync
  );

  // Reorder buffer side
  modport slave (
    input  i_ce, i_sync, i_lgsize, i_bypass, i_in,
    output o_out, o_sync
  );
endinterface

// File: rtl/bitreverse_var.sv
// Runtime-sized bit-reversal reorder buffer: bit-reversed in, natural order out, framed by o_sync.
// Latency: frame F sample 0 emerges N+1 strobes after it entered; bypass is 1 strobe.
// No backpressure: every i_ce consumes one sample and advances the output; i_ce low freezes everything.
//
// Ports
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset
//   bus      sample stream (slave side): i_ce, i_sync, i_lgsize, i_bypass, i_in -> o_out, o_sync
//
// Memory holds two banks of 2^LGMAXSIZE words. One bank is written with the
// incoming frame while the other, holding the previous complete frame, is
// read in natural order. Frame size and bypass are latched at frame start.
module bitreverse_var #(
  parameter int LGMAXSIZE = 10,
  parameter int WIDTH     = 16,
  parameter int LGW       = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  bitreverse_var_if.slave bus
);

  localparam int AW = LGMAXSIZE;     // index width within one bank
  localparam int DW = 2 * WIDTH;     // sample word width
  localparam logic [LGW-1:0] LG_MAX = LGW'(LGMAXSIZE);
  localparam logic [LGW-1:0] LG_MIN = LGW'(1);

  // BYPASS is kept as its own state so pass-through needs no memory access.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    RUN    = 2'd2,
    BYPASS = 2'd3
  } state_t;

  // What the output register loads on an accepted strobe.
  typedef enum logic [1:0] {
    OUT_HOLD = 2'd0,
    OUT_MEM  = 2'd1,
    OUT_BYP  = 2'd2
  } out_sel_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [AW-1:0]  k_q, k_d;          // index of the next sample within the frame
  logic           bank_q, bank_d;    // bank currently being written
  logic [LGW-1:0] lg_q, lg_d;        // latched, clamped log2 frame size
  logic           byp_q, byp_d;      // latched bypass
  logic           sync_q, sync_d;
  logic [DW-1:0]  out_q;

  logic [DW-1:0]  mem [0:(1<<(AW+1))-1];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [LGW-1:0] lg_req;            // clamped request on i_lgsize
  logic [LGW-1:0] lg_eff;            // size governing this strobe
  logic           cfg_diff;
  logic           restart;           // this strobe starts a fresh frame from scratch
  logic [AW-1:0]  cur_k;             // index of the sample on i_in this strobe
  logic [AW:0]    n_eff;
  logic [AW-1:0]  last_k;
  logic [AW-1:0]  rev_full;
  logic [LGW-1:0] rev_shamt;
  logic [AW-1:0]  rev_k;
  logic [AW:0]    wr_addr;
  logic [AW:0]    rd_addr;
  logic           mem_we;
  out_sel_t       out_sel;

  // Clamp the requested size into [1, LGMAXSIZE].
  always_comb begin
    lg_req = bus.i_lgsize;
    if (bus.i_lgsize == '0) begin
      lg_req = LG_MIN;
    end else if (bus.i_lgsize > LG_MAX) begin
      lg_req = LG_MAX;
    end
  end

  assign cfg_diff = (lg_req != lg_q) || (bus.i_bypass != byp_q);

  // A sync restarts the frame unless it lands exactly on the expected frame
  // boundary with an unchanged configuration. From IDLE and BYPASS every sync
  // relatches the configuration.
  always_comb begin
    restart = 1'b0;
    if (bus.i_ce && bus.i_sync) begin
      case (state_q)
        FILL, RUN: restart = (k_q != '0) || cfg_diff;
        default:   restart = 1'b1;
      endcase
    end
  end

  assign lg_eff = restart ? lg_req : lg_q;
  assign cur_k  = restart ? '0 : k_q;
  assign n_eff  = (AW+1)'(1) << lg_eff;
  assign last_k = AW'(n_eff - (AW+1)'(1));

  // Reverse the low lg_eff bits of cur_k: reverse all AW bits, then shift the
  // result down so the reversed field lands at bit 0. cur_k < 2^lg_eff, so the
  // bits shifted out are zero and the upper result bits come out zero.
  always_comb begin
    for (int i = 0; i < AW; i++) begin
      rev_full[i] = cur_k[AW-1-i];
    end
  end

  assign rev_shamt = LG_MAX - lg_eff;
  assign rev_k     = rev_full >> rev_shamt;

  // The read bank is always the one not being written, so the two ports never
  // collide.
  assign wr_addr = {bank_q, cur_k};
  assign rd_addr = {~bank_q, rev_k};

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bank_d  = bank_q;
    lg_d    = lg_q;
    byp_d   = byp_q;
    sync_d  = sync_q;
    mem_we  = 1'b0;
    out_sel = OUT_HOLD;

    if (bus.i_ce) begin
      sync_d = 1'b0;

      if (restart) begin
        lg_d  = lg_req;
        byp_d = bus.i_bypass;
      end

      if (restart && bus.i_bypass) begin
        // Entering (or staying in) bypass: this sync passes straight through.
        state_d = BYPASS;
        k_d     = '0;
        out_sel = OUT_BYP;
        sync_d  = 1'b1;
      end else if ((state_q == BYPASS) && !restart) begin
        out_sel = OUT_BYP;
        sync_d  = bus.i_sync;
      end else if (restart || (state_q == FILL)) begin
        // Filling a frame: nothing valid to emit yet, o_out holds.
        mem_we = 1'b1;
        if (cur_k == last_k) begin
          bank_d  = ~bank_q;
          k_d     = '0;
          state_d = RUN;
        end else begin
          k_d     = cur_k + AW'(1);
          state_d = FILL;
        end
      end else if (state_q == RUN) begin
        // Steady state; a missing sync at the frame boundary is ignored and
        // the index simply wraps.
        mem_we  = 1'b1;
        out_sel = OUT_MEM;
        sync_d  = (cur_k == '0);
        if (cur_k == last_k) begin
          bank_d = ~bank_q;
          k_d    = '0;
        end else begin
          k_d    = cur_k + AW'(1);
        end
      end
      // IDLE without sync: data ignored.
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      bank_q  <= 1'b0;
      lg_q    <= LG_MIN;
      byp_q   <= 1'b0;
      sync_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bank_q  <= bank_d;
      lg_q    <= lg_d;
      byp_q   <= byp_d;
      sync_q  <= sync_d;
      case (out_sel)
        OUT_MEM: out_q <= mem[rd_addr];
        OUT_BYP: out_q <= bus.i_in;
        default: out_q <= out_q;
      endcase
    end
  end

  // Single write port; no reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) begin
      mem[wr_addr] <= bus.i_in;
    end
  end

  assign bus.o_out  = out_q;
  assign bus.o_sync = sync_q;

endmodule

// File: tb/tb_bitreverse_var.sv
// Testbench for bitreverse_var: directed scenarios plus randomized frame
// streams, every strobe compared against a natural-order frame model.
module tb_bitreverse_var;

  localparam int LGMAX = 10;
  localparam int MAXN  = 1 << LGMAX;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_RUN  = 2;
  localparam int M_BYP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bitreverse_var_if #(.WIDTH(16), .LGW(4)) bus ();

  bitreverse_var #(.LGMAXSIZE(LGMAX), .WIDTH(16), .LGW(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int gap      = 0;
  int sync_seen = 0;

  // Reference model: frames kept as arrays indexed by natural sample number.
  int          m_mode;
  int          m_lg;
  bit          m_byp;
  int          m_pos;
  logic [31:0] m_cur  [MAXN];
  logic [31:0] m_prev [MAXN];
  logic [31:0] exp_out;
  logic        exp_sync;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input logic [3:0] lg);
    if (lg == 4'd0) return 1;
    if (int'(lg) > LGMAX) return LGMAX;
    return int'(lg);
  endfunction

  // Reverse the low l bits of x, arithmetically.
  function automatic int rev(input int x, input int l);
    int r = 0;
    for (int i = 0; i < l; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_lg     = 1;
    m_byp    = 1'b0;
    m_pos    = 0;
    exp_out  = '0;
    exp_sync = 1'b0;
  endtask

  task automatic model_step(input bit sync, input logic [3:0] lg, input bit byp, input logic [31:0] d);
    int  l;
    bit  fresh;
    l = clamp(lg);
    fresh = 1'b0;
    if (sync) begin
      if (m_mode == M_IDLE || m_mode == M_BYP) fresh = 1'b1;
      else if (m_pos != 0 || l != m_lg || byp != m_byp) fresh = 1'b1;
    end
    if (fresh) begin
      m_lg  = l;
      m_byp = byp;
      m_pos = 0;
      m_mode = byp ? M_BYP : M_FILL;
    end
    case (m_mode)
      M_BYP: begin
        exp_out  = d;
        exp_sync = sync;
      end
      M_FILL: begin
        exp_sync = 1'b0;
        m_cur[rev(m_pos, m_lg)] = d;
        m_pos++;
        if (m_pos == (1 << m_lg)) begin
          m_prev = m_cur;
          m_pos  = 0;
          m_mode = M_RUN;
        end
      end
      M_RUN: begin
        exp_out  = m_prev[m_pos];
        exp_sync = (m_pos == 0);
        m_cur[rev(m_pos, m_lg)] = d;
        m_pos++;
        if (m_pos == (1 << m_lg)) begin
          m_prev = m_cur;
          m_pos  = 0;
        end
      end
      default: exp_sync = 1'b0;
    endcase
  endtask

  task automatic drive(input bit ce, input bit sync, input logic [3:0] lg, input bit byp, input logic [31:0] d);
    @(negedge clk);
    bus.i_ce     = ce;
    bus.i_sync   = sync;
    bus.i_lgsize = lg;
    bus.i_bypass = byp;
    bus.i_in     = d;
    @(posedge clk);
    if (ce) model_step(sync, lg, byp, d);
    #1;
    check("out", 64'(bus.o_out), 64'(exp_out));
    check("sync", 64'(bus.o_sync), 64'(exp_sync));
    if (ce && bus.o_sync) sync_seen++;
  endtask

  // One accepted sample, preceded by `gap` idle clocks carrying junk.
  task automatic strobe(input bit sync, input logic [3:0] lg, input bit byp, input logic [31:0] d);
    for (int g = 0; g < gap; g++)
      drive(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), $urandom);
    drive(1'b1, sync, lg, byp, d);
  endtask

  // Samples in bit-reversed order; low half of each word is its natural index.
  task automatic send_frame(input logic [3:0] lg, input bit byp, input int nsend, input bit do_sync);
    int l;
    int n;
    l = clamp(lg);
    n = 1 << l;
    for (int j = 0; j < nsend; j++) begin
      logic [31:0] d;
      d = {16'($urandom), 16'(rev(j % n, l))};
      if (j == 0) strobe(do_sync, lg, byp, d);
      else        strobe(1'b0, 4'($urandom), 1'($urandom), d);
    end
  endtask

  task automatic do_reset(input bit with_ce);
    @(negedge clk);
    rst          = 1'b1;
    bus.i_ce     = with_ce;
    bus.i_sync   = 1'b1;
    bus.i_lgsize = 4'd3;
    bus.i_bypass = 1'b0;
    bus.i_in     = $urandom;
    @(posedge clk);
    model_reset();
    #1;
    check("rst_out", 64'(bus.o_out), 64'd0);
    check("rst_sync", 64'(bus.o_sync), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    bus.i_ce = 1'b0;
    bus.i_sync = 1'b0;
  endtask

  // Second frame of size 2^lg sent with explicit natural-order checks.
  task automatic frame_natural(input string tag, input logic [3:0] lg);
    int l;
    l = clamp(lg);
    for (int j = 0; j < (1 << l); j++) begin
      strobe(j == 0, lg, 1'b0, {16'($urandom), 16'(rev(j, l))});
      check({tag, "_nat"}, 64'(bus.o_out[15:0]), 64'(j));
      check({tag, "_sync"}, 64'(bus.o_sync), 64'(j == 0));
    end
  endtask

  initial begin
    logic [3:0] lg_r;
    bus.i_ce = 1'b0; bus.i_sync = 1'b0; bus.i_lgsize = '0; bus.i_bypass = 1'b0; bus.i_in = '0;
    model_reset();

    // 1: size 8, continuous strobes; first output on the 9th strobe
    gap = 0;
    do_reset(1'b0);
    send_frame(4'd3, 1'b0, 8, 1'b1);
    frame_natural("t1", 4'd3);

    // 2: strobe every third clock; exactly one o_sync in the emitted frame
    gap = 2;
    do_reset(1'b0);
    send_frame(4'd3, 1'b0, 8, 1'b1);
    sync_seen = 0;
    frame_natural("t2", 4'd3);
    check("t2_one_sync", 64'(sync_seen), 64'd1);

    // 3: size change 8 -> 32 at a frame start
    gap = 0;
    do_reset(1'b0);
    send_frame(4'd3, 1'b0, 8, 1'b1);
    send_frame(4'd3, 1'b0, 8, 1'b1);
    sync_seen = 0;
    send_frame(4'd5, 1'b0, 32, 1'b1);
    check("t3_nosync", 64'(sync_seen), 64'd0);
    frame_natural("t3", 4'd5);

    // 4: resync at k=5 while running
    do_reset(1'b0);
    send_frame(4'd3, 1'b0, 8, 1'b1);
    send_frame(4'd3, 1'b0, 8, 1'b1);
    send_frame(4'd3, 1'b0, 5, 1'b1);
    sync_seen = 0;
    send_frame(4'd3, 1'b0, 8, 1'b1);
    check("t4_nosync", 64'(sync_seen), 64'd0);
    frame_natural("t4", 4'd3);

    // 5: bypass, then leave bypass at a frame start
    do_reset(1'b0);
    strobe(1'b1, 4'd3, 1'b1, 32'hA5A5_0001);
    check("t5_out", 64'(bus.o_out), 64'hA5A5_0001);
    check("t5_sync", 64'(bus.o_sync), 64'd1);
    strobe(1'b0, 4'd7, 1'b0, 32'h1234_5678);
    check("t5_out2", 64'(bus.o_out), 64'h1234_5678);
    check("t5_sync2", 64'(bus.o_sync), 64'd0);
    strobe(1'b1, 4'd3, 1'b0, 32'h0000_0000);
    check("t5_leave_hold", 64'(bus.o_out), 64'h1234_5678);

    // 6: reset mid-run, with i_ce high on the reset cycle
    do_reset(1'b0);
    send_frame(4'd3, 1'b0, 8, 1'b1);
    send_frame(4'd3, 1'b0, 8, 1'b1);
    send_frame(4'd3, 1'b0, 3, 1'b1);
    do_reset(1'b1);
    sync_seen = 0;
    send_frame(4'd3, 1'b0, 5, 1'b0);
    check("t6_idle_sync", 64'(sync_seen), 64'd0);
    check("t6_idle_out", 64'(bus.o_out), 64'd0);

    // Clamp boundaries: lgsize 0 -> size 2, lgsize 12 -> size 1024
    do_reset(1'b0);
    send_frame(4'd0, 1'b0, 2, 1'b1);
    frame_natural("clamp_lo", 4'd0);
    send_frame(4'd12, 1'b0, 1024, 1'b1);
    frame_natural("clamp_hi", 4'd12);

    // Randomized frame stream
    do_reset(1'b0);
    lg_r = 4'd3;
    for (int f = 0; f < 200; f++) begin
      int  n;
      int  nsend;
      bit  byp;
      bit  dosync;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if ($urandom_range(0, 3) == 0) lg_r = 4'($urandom_range(0, 5));
      byp    = ($urandom_range(0, 11) == 0);
      n      = 1 << clamp(lg_r);
      nsend  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, n) : n;
      dosync = ($urandom_range(0, 9) != 0);
      send_frame(lg_r, byp, nsend, dosync);
      if ($urandom_range(0, 49) == 0) do_reset(1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
